// File: rtl/gate_vector_sequencer_pkg.sv
// Shared definitions for the exhaustive gate self-test sequencer:
// op encodings, FSM states and the reference reduction function.
package gate_vector_sequencer_pkg;

  localparam logic [2:0] OP_AND         = 3'd0;
  localparam logic [2:0] OP_OR          = 3'd1;
  localparam logic [2:0] OP_NAND        = 3'd2;
  localparam logic [2:0] OP_NOR         = 3'd3;
  localparam logic [2:0] OP_XOR         = 3'd4;
  localparam logic [2:0] OP_XNOR        = 3'd5;
  localparam logic [2:0] OP_ILLEGAL_MIN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Reference reduction of the low n_in bits of vec. Unused upper bits are
  // padded with ones for AND-type reductions and zeros for OR/XOR-type ones,
  // so any gate width 1..8 shares one 8-bit implementation.
  function automatic logic gate_expected(input logic [2:0] op,
                                         input logic [7:0] vec,
                                         input int         n_in);
    logic [7:0] mask;
    logic       and_v;
    logic       or_v;
    logic       xor_v;
    mask  = 8'hFF >> (8 - n_in);
    and_v = &(vec | ~mask);
    or_v  = |(vec & mask);
    xor_v = ^(vec & mask);
    case (op)
      OP_AND:  gate_expected = and_v;
      OP_OR:   gate_expected = or_v;
      OP_NAND: gate_expected = ~and_v;
      OP_NOR:  gate_expected = ~or_v;
      OP_XOR:  gate_expected = xor_v;
      OP_XNOR: gate_expected = ~xor_v;
      default: gate_expected = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational expected-value generator: reduction of the applied vector
// according to the latched op.
module gate_ref_model
  import gate_vector_sequencer_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      i_op,
  input  logic [N_IN-1:0] i_vec,
  output logic            o_y_exp
);

  logic [7:0] w_vec8;

  assign w_vec8 = 8'(i_vec);

  // Expected gate output for the vector currently on the bus
  always_comb begin
    o_y_exp = 1'b0;
    o_y_exp = gate_expected(i_op, w_vec8, N_IN);
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive self-test sequencer for an N_IN-input combinational gate:
// applies every vector, waits SETTLE cycles, compares the gate output with
// the reference reduction and reports mismatch count, first failing vector
// and pass/fail.
module gate_vector_sequencer
  import gate_vector_sequencer_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  output logic [N_IN-1:0] o_vec,
  input  logic            i_dut_y,
  output logic            o_busy,
  output logic            o_chk_valid,
  output logic            o_chk_fail,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic [N_IN-1:0] o_first_fail
);

  localparam int              ERR_W       = N_IN + 1;
  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);
  // Last value the settle counter reaches before leaving WAIT
  localparam logic [3:0]      SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_e           r_state;
  logic [2:0]       r_op;
  logic [3:0]       r_cnt;
  logic [N_IN-1:0]  r_vec;
  logic             r_busy;
  logic             r_chk_valid;
  logic             r_chk_fail;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_count;
  logic [N_IN-1:0]  r_first_fail;

  logic             w_y_exp;
  logic             w_mismatch;

  gate_ref_model #(
    .N_IN (N_IN)
  ) u_ref (
    .i_op    (r_op),
    .i_vec   (r_vec),
    .o_y_exp (w_y_exp)
  );

  // dut_y only matters in CHECK; elsewhere this value is ignored
  assign w_mismatch = (i_dut_y != w_y_exp);

  // Sequencer FSM with all result registers; reset abandons any run
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_op         <= 3'd0;
      r_cnt        <= 4'd0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_chk_valid  <= 1'b0;
      r_chk_fail   <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_first_fail <= '0;
    end else begin
      r_chk_valid <= 1'b0;
      r_chk_fail  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_op         <= i_op;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_pass       <= 1'b0;
            r_vec        <= '0;
            if (i_op >= OP_ILLEGAL_MIN) begin
              // Illegal op: report failure at once, no vectors applied
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_APPLY;
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          r_cnt   <= 4'd0;
          r_state <= (SETTLE > 0) ? ST_WAIT : ST_CHECK;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_chk_valid <= 1'b1;
          r_chk_fail  <= w_mismatch;
          if (w_mismatch) begin
            r_err_count <= r_err_count + ERR_ONE;
            if (r_err_count == '0) begin
              r_first_fail <= r_vec;
            end
          end
          // Terminal test precedes increment so vec holds all-ones in DONE
          if (r_vec == VEC_LAST) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_err_count == '0) && !w_mismatch;
          end else begin
            r_vec   <= r_vec + VEC_ONE;
            r_state <= ST_APPLY;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_vec        = r_vec;
  assign o_busy       = r_busy;
  assign o_chk_valid  = r_chk_valid;
  assign o_chk_fail   = r_chk_fail;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err_count;
  assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench: a 2-input AND gate sequenced with SETTLE=1 and a stuck-at-0
// 3-input gate sequenced with SETTLE=0.
module tb_gate_vector_sequencer;
  import gate_vector_sequencer_pkg::*;

  logic       clk;
  logic       rst;

  // 2-input instance
  logic       start2;
  logic [2:0] op2;
  logic [1:0] vec2;
  logic       y2;
  logic       busy2, cv2, cf2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] ff2;

  // 3-input instance
  logic       start3;
  logic [2:0] op3;
  logic [2:0] vec3;
  logic       y3;
  logic       busy3, cv3, cf3, done3, pass3;
  logic [3:0] err3;
  logic [2:0] ff3;

  int n_total;
  int n_bad;
  int nv;
  int nf;

  assign y2 = &vec2;
  assign y3 = 1'b0;

  gate_vector_sequencer #(.N_IN(2), .SETTLE(1)) u_dut2 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start2),
    .i_op         (op2),
    .o_vec        (vec2),
    .i_dut_y      (y2),
    .o_busy       (busy2),
    .o_chk_valid  (cv2),
    .o_chk_fail   (cf2),
    .o_done       (done2),
    .o_pass       (pass2),
    .o_err_count  (err2),
    .o_first_fail (ff2)
  );

  gate_vector_sequencer #(.N_IN(3), .SETTLE(0)) u_dut3 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start3),
    .i_op         (op3),
    .o_vec        (vec3),
    .i_dut_y      (y3),
    .o_busy       (busy3),
    .o_chk_valid  (cv3),
    .o_chk_fail   (cf3),
    .o_done       (done3),
    .o_pass       (pass3),
    .o_err_count  (err3),
    .o_first_fail (ff3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 2-input run; optional extra start pulses (with a different op) at
  // cycles ig_a/ig_b after acceptance must be ignored.
  task automatic run2(input logic [2:0] op, input int ig_a, input int ig_b,
                      output int n_valid, output int n_fail);
    start2 = 1'b1;
    op2    = op;
    tick();
    start2 = 1'b0;
    chk_eq("busy_after_accept", {31'd0, busy2}, 32'd1);
    chk_eq("vec_after_accept", {30'd0, vec2}, 32'd0);
    n_valid = 0;
    n_fail  = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == ig_a || c == ig_b) begin
        start2 = 1'b1;
        op2    = op ^ 3'd1;
      end
      tick();
      start2 = 1'b0;
      op2    = op;
      if (c == 11) chk_eq("done_not_early", {31'd0, done2}, 32'd0);
      if (c % 3 == 0 && c < 12) chk_eq("vec_step", {30'd0, vec2}, c / 3);
      if (cv2) begin
        n_valid++;
        if (cf2) n_fail++;
      end
    end
    chk_eq("done_at_12", {31'd0, done2}, 32'd1);
    chk_eq("busy_clear_at_done", {31'd0, busy2}, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    start2  = 1'b0;
    op2     = 3'd0;
    start3  = 1'b0;
    op3     = 3'd0;
    tick();
    tick();
    chk_eq("rst_vec", {30'd0, vec2}, 32'd0);
    chk_eq("rst_flags", {27'd0, busy2, cv2, cf2, done2, pass2}, 32'd0);
    chk_eq("rst_err", {29'd0, err2}, 32'd0);
    chk_eq("rst_ff", {30'd0, ff2}, 32'd0);
    rst = 1'b0;
    tick();

    // Correct gate, AND expected
    run2(OP_AND, 0, 0, nv, nf);
    chk_eq("and_valid_cnt", nv, 32'd4);
    chk_eq("and_fail_cnt", nf, 32'd0);
    chk_eq("and_pass", {31'd0, pass2}, 32'd1);
    chk_eq("and_err", {29'd0, err2}, 32'd0);
    chk_eq("and_ff", {30'd0, ff2}, 32'd0);
    chk_eq("and_vec_hold", {30'd0, vec2}, 32'd3);
    tick();
    tick();
    chk_eq("and_done_hold", {30'd0, done2, pass2}, 32'd3);

    // Wrong function: OR expected against an AND gate
    run2(OP_OR, 0, 0, nv, nf);
    chk_eq("or_fail_cnt", nf, 32'd2);
    chk_eq("or_err", {29'd0, err2}, 32'd2);
    chk_eq("or_ff", {30'd0, ff2}, 32'd1);
    chk_eq("or_pass", {31'd0, pass2}, 32'd0);

    // Illegal op
    start2 = 1'b1;
    op2    = 3'd6;
    tick();
    start2 = 1'b0;
    op2    = 3'd0;
    chk_eq("ill_done", {31'd0, done2}, 32'd1);
    chk_eq("ill_pass", {31'd0, pass2}, 32'd0);
    chk_eq("ill_err", {29'd0, err2}, 32'd0);
    chk_eq("ill_vec", {30'd0, vec2}, 32'd0);
    chk_eq("ill_busy", {31'd0, busy2}, 32'd0);
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      if (cv2) nv++;
      tick();
    end
    chk_eq("ill_no_valid", nv, 32'd0);

    // Reset during WAIT of vec=2 (edge 7 after acceptance enters WAIT)
    start2 = 1'b1;
    op2    = OP_OR;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 7; c++) tick();
    chk_eq("pre_rst_vec", {30'd0, vec2}, 32'd2);
    chk_eq("pre_rst_err", {29'd0, err2}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("midrst_vec", {30'd0, vec2}, 32'd0);
    chk_eq("midrst_flags", {27'd0, busy2, cv2, cf2, done2, pass2}, 32'd0);
    chk_eq("midrst_err_ff", {27'd0, err2, ff2}, 32'd0);
    run2(OP_AND, 0, 0, nv, nf);
    chk_eq("restart_pass", {31'd0, pass2}, 32'd1);
    chk_eq("restart_valid_cnt", nv, 32'd4);

    // Start pulses while busy must be ignored
    run2(OP_AND, 3, 7, nv, nf);
    chk_eq("ign_pass", {31'd0, pass2}, 32'd1);
    chk_eq("ign_err", {29'd0, err2}, 32'd0);
    chk_eq("ign_valid_cnt", nv, 32'd4);

    // 3-input, SETTLE=0, output stuck at 0, AND expected
    start3 = 1'b1;
    op3    = OP_AND;
    tick();
    start3 = 1'b0;
    nv = 0;
    nf = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) chk_eq("n3_done_not_early", {31'd0, done3}, 32'd0);
      if (c == 2) chk_eq("n3_vec_step", {29'd0, vec3}, 32'd1);
      if (cv3) begin
        nv++;
        if (cf3) nf++;
      end
    end
    chk_eq("n3_done_at_16", {31'd0, done3}, 32'd1);
    chk_eq("n3_valid_cnt", nv, 32'd8);
    chk_eq("n3_err", {28'd0, err3}, 32'd1);
    chk_eq("n3_ff", {29'd0, ff3}, 32'd7);
    chk_eq("n3_pass", {31'd0, pass3}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Synthesizable exhaustive self-test stage wrapped around a combinational N-input logic gate.
- Upstream side: drives every input vector 0..2^N_IN-1 onto the gate's inputs.
- Downstream side: samples the gate output after a settle window and compares it with the expected reduction function.
- Reports error count, first failing vector and pass/fail. It is the hardware counterpart of the per-vector apply/wait/check bench routine used on our gate primitives.

Parameters:
- N_IN, 2, number of gate inputs (1..8).
- SETTLE, 1, cycles between vector apply and output sample (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle run request; honoured only in IDLE or DONE
- op  input  3  expected function, sampled on accepted start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
- vec  output  N_IN  registered vector driven to the gate under test
- dut_y  input  1  gate output being checked
- busy  output  1  high from the cycle after an accepted start until DONE is entered
- chk_valid  output  1  one-cycle pulse on each compare
- chk_fail  output  1  qualified by chk_valid; 1 = mismatch on this vector
- done  output  1  high while in DONE
- pass  output  1  valid while done; 1 = zero mismatches and legal op
- err_count  output  N_IN+1  mismatches in the current or last run
- first_fail  output  N_IN  vec of the first mismatch; 0 if none

Behaviour:
- Reset (rst=1 at clk edge, any state):
  - state=IDLE; all outputs 0 (vec, busy, chk_valid, chk_fail, done, pass, err_count, first_fail).
  - Reset mid-run abandons the run with no partial report.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE + start:
  - Latch op; clear err_count, first_fail, done and pass.
  - vec<=0. Go to APPLY, or to DONE with pass=0 if op is 6/7 (no vectors applied).
- APPLY (1 cycle): vec held. Settle counter <=0. Go to WAIT if SETTLE>0, else CHECK.
- WAIT: counter increments each cycle; leave to CHECK after exactly SETTLE cycles.
- CHECK (1 cycle):
  - Expected value is the reduction of vec per latched op (NAND = ~&vec, etc.), compared with dut_y sampled this cycle.
  - chk_valid=1 and chk_fail=mismatch are registered, visible the cycle after CHECK.
  - On mismatch: err_count+1; first_fail<=vec if err_count was 0.
  - If vec = all-ones: go to DONE. Otherwise vec<=vec+1 and go to APPLY.
- Per-vector cost: SETTLE+2 cycles. Full run: 2^N_IN*(SETTLE+2) cycles from start acceptance to DONE entry.
- DONE:
  - done=1; pass = (err_count==0) and legal op.
  - Results hold until the next accepted start or reset. vec holds the last value.
- start while busy is ignored and has no effect on op or counters.
- err_count never wraps: its width holds 2^N_IN.
- Vector counter wraps internally only at terminal detection; the all-ones test precedes increment.
- Simultaneous rst and start: rst wins.
- dut_y is sampled only in CHECK; glitches elsewhere are irrelevant.

Decomposition:
- Shared package holds:
  - op encoding constants (OP_AND..OP_XNOR, OP_ILLEGAL_MIN=6);
  - state enumeration;
  - a function `gate_expected(op, vec)` returning the reference reduction.
  - The bench reuses this function.
- One natural sub-module: `gate_ref_model`, a combinational expected-value generator (op, vec -> y_exp). The FSM, counters and result registers stay in the top.

Test Plan:
- Correct gate: N_IN=2, SETTLE=1, and_gate instance, op=0, start pulse.
  - vec steps 0,1,2,3 every 3 cycles.
  - 4 chk_valid pulses, all chk_fail=0.
  - done 12 cycles after acceptance; pass=1, err_count=0, first_fail=0.
- Wrong function: same gate, op=1 (OR expected).
  - Mismatches at vec=1,2.
  - err_count=2, first_fail=2'b01, pass=0.
- Illegal op: op=6, start.
  - DONE on the next cycle; pass=0, err_count=0.
  - vec stays 0; no chk_valid.
- Reset and restart: assert rst during WAIT of vec=2.
  - All outputs 0 next cycle; state IDLE.
  - New start with op=0 completes a clean 12-cycle run with pass=1.
- Start ignored while busy: start pulses at cycles 3 and 7 of a run.
  - Run timing is unchanged (done at 12).
  - op change at the ignored start is not latched.
- SETTLE=0 and N_IN=3 with a forced-stuck dut_y=0 and op=0 (AND).
  - 8 vectors at 2 cycles each; done at 16.
  - Only vec=7 mismatches: err_count=1, first_fail=3'b111.
